// File: rtl/tdm_slot_demux_pkg.sv
// Shared definitions for the TDM slot demultiplexer: state encodings,
// mux select constants and slot counter sizing.
package tdm_slot_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SLOT_A = 2'd1,
    ST_SLOT_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // A single-cycle slot still needs one counter bit so the port stays legal.
  function automatic int cnt_width(input int slot_cycles);
    return (slot_cycles <= 2) ? 1 : $clog2(slot_cycles);
  endfunction

endpackage

// File: rtl/tdm_slot_demux_slot_counter.sv
// Counts clock cycles within one TDM slot and flags the final cycle.
// Self-clears on the last cycle so consecutive slots need no idle gap.
module tdm_slot_demux_slot_counter
  import tdm_slot_demux_pkg::*;
#(
  parameter int SLOT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic last
);

  localparam int CW = cnt_width(SLOT_CYCLES);
  localparam logic [CW-1:0] LAST_VAL = CW'(SLOT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // The count only returns to zero by clear or at the slot end, never by overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      if (last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/tdm_slot_demux.sv
// Drives the upstream 2:1 mux select on an A/B slot schedule and captures the
// shared line at the end of each slot into two registered channel outputs.
module tdm_slot_demux
  import tdm_slot_demux_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SLOT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] mux_in,
  output logic             sel,
  output logic [WIDTH-1:0] ch_a,
  output logic [WIDTH-1:0] ch_b,
  output logic             valid_a,
  output logic             valid_b,
  output logic             frame_done,
  output logic             busy
);

  state_t state;
  logic   in_slot;
  logic   slot_last;

  assign in_slot = (state == ST_SLOT_A) || (state == ST_SLOT_B);

  tdm_slot_demux_slot_counter #(
    .SLOT_CYCLES(SLOT_CYCLES)
  ) u_slot_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(!in_slot),
    .run  (in_slot),
    .last (slot_last)
  );

  // sel and busy change on the same edge as state, so sel mirrors SLOT_B exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= SEL_A;
      busy       <= 1'b0;
      ch_a       <= '0;
      ch_b       <= '0;
      valid_a    <= 1'b0;
      valid_b    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_a    <= 1'b0;
      valid_b    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            state <= ST_SLOT_A;
            sel   <= SEL_A;
            busy  <= 1'b1;
          end
        end
        ST_SLOT_A: begin
          if (slot_last) begin
            ch_a    <= mux_in;
            valid_a <= 1'b1;
            state   <= ST_SLOT_B;
            sel     <= SEL_B;
          end
        end
        ST_SLOT_B: begin
          if (slot_last) begin
            ch_b       <= mux_in;
            valid_b    <= 1'b1;
            frame_done <= 1'b1;
            sel        <= SEL_A;
            if (en) begin
              state <= ST_SLOT_A;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          sel   <= SEL_A;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_slot_demux.sv
// Directed self-checking bench for tdm_slot_demux with a 2:1 mux model on the
// shared line; covers SLOT_CYCLES=2 and a second SLOT_CYCLES=1 instance.
module tb_tdm_slot_demux;

  logic clk;
  logic rst_n;
  logic en;
  logic en_fast;
  logic x;
  logic y;

  logic       mux_in;
  logic       sel;
  logic [0:0] ch_a;
  logic [0:0] ch_b;
  logic       valid_a;
  logic       valid_b;
  logic       frame_done;
  logic       busy;

  logic       mux_in_fast;
  logic       sel_fast;
  logic [0:0] ch_a_fast;
  logic [0:0] ch_b_fast;
  logic       valid_a_fast;
  logic       valid_b_fast;
  logic       frame_done_fast;
  logic       busy_fast;

  int num_checks;
  int num_errors;

  assign mux_in      = (x & ~sel)      | (y & sel);
  assign mux_in_fast = (x & ~sel_fast) | (y & sel_fast);

  tdm_slot_demux #(
    .WIDTH      (1),
    .SLOT_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mux_in    (mux_in),
    .sel       (sel),
    .ch_a      (ch_a),
    .ch_b      (ch_b),
    .valid_a   (valid_a),
    .valid_b   (valid_b),
    .frame_done(frame_done),
    .busy      (busy)
  );

  tdm_slot_demux #(
    .WIDTH      (1),
    .SLOT_CYCLES(1)
  ) dut_fast (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_fast),
    .mux_in    (mux_in_fast),
    .sel       (sel_fast),
    .ch_a      (ch_a_fast),
    .ch_b      (ch_b_fast),
    .valid_a   (valid_a_fast),
    .valid_b   (valid_b_fast),
    .frame_done(frame_done_fast),
    .busy      (busy_fast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic actual, input logic expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en_v, input logic x_v, input logic y_v);
    en = en_v;
    x  = x_v;
    y  = y_v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic xv;
    logic yv;
    num_checks = 0;
    num_errors = 0;
    rst_n   = 1'b0;
    en_fast = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Reset held with en=1: everything stays quiet.
    #3;
    checkOutput("rst_sel", sel, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ch_a", ch_a[0], 1'b0);
    checkOutput("rst_ch_b", ch_b[0], 1'b0);
    tick();
    tick();
    checkOutput("rst_held_busy", busy, 1'b0);
    checkOutput("rst_held_valid_a", valid_a, 1'b0);
    checkOutput("rst_fast_busy", busy_fast, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 0);
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("idle_no_en_busy", busy, 1'b0);

    // Single frame, x=1 y=0.
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("f1_e1_sel", sel, 1'b0);
    checkOutput("f1_e1_busy", busy, 1'b1);
    tick();
    checkOutput("f1_e2_sel", sel, 1'b0);
    checkOutput("f1_e2_valid_a", valid_a, 1'b0);
    tick();
    checkOutput("f1_e3_valid_a", valid_a, 1'b1);
    checkOutput("f1_e3_ch_a", ch_a[0], 1'b1);
    checkOutput("f1_e3_sel", sel, 1'b1);
    tick();
    checkOutput("f1_e4_sel", sel, 1'b1);
    checkOutput("f1_e4_valid_a", valid_a, 1'b0);
    checkOutput("f1_e4_valid_b", valid_b, 1'b0);
    tick();
    checkOutput("f1_e5_valid_b", valid_b, 1'b1);
    checkOutput("f1_e5_frame_done", frame_done, 1'b1);
    checkOutput("f1_e5_ch_b", ch_b[0], 1'b0);
    checkOutput("f1_e5_busy", busy, 1'b0);
    checkOutput("f1_e5_sel", sel, 1'b0);
    tick();
    checkOutput("f1_e6_valid_b", valid_b, 1'b0);
    checkOutput("f1_e6_frame_done", frame_done, 1'b0);

    // Continuous frames over all x/y combinations; en drops before the last B capture.
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      xv = k[1];
      yv = k[0];
      applyStimulus(1'b1, xv, yv);
      tick();
      checkOutput("cont_mid_valid_a", valid_a, 1'b0);
      tick();
      checkOutput("cont_valid_a", valid_a, 1'b1);
      checkOutput("cont_ch_a", ch_a[0], xv);
      checkOutput("cont_sel_b", sel, 1'b1);
      tick();
      if (k == 3) applyStimulus(1'b0, xv, yv);
      tick();
      checkOutput("cont_valid_b", valid_b, 1'b1);
      checkOutput("cont_frame_done", frame_done, 1'b1);
      checkOutput("cont_ch_b", ch_b[0], yv);
      checkOutput("cont_busy", busy, (k != 3));
      checkOutput("cont_valid_a_off", valid_a, 1'b0);
    end
    tick();

    // Abort: reset during SLOT_B of the second frame.
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    tick();
    tick();
    checkOutput("abort_f1_done", frame_done, 1'b1);
    tick();
    tick();
    checkOutput("abort_f2_ch_a", ch_a[0], 1'b1);
    tick();
    #2;
    applyStimulus(1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_sel", sel, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_ch_a", ch_a[0], 1'b0);
    checkOutput("abort_ch_b", ch_b[0], 1'b0);
    tick();
    checkOutput("abort_no_frame_done", frame_done, 1'b0);
    checkOutput("abort_no_valid_b", valid_b, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("restart_valid_a", valid_a, 1'b1);
    checkOutput("restart_ch_a", ch_a[0], 1'b0);
    tick();
    tick();
    checkOutput("restart_frame_done", frame_done, 1'b1);
    checkOutput("restart_ch_b", ch_b[0], 1'b1);
    checkOutput("restart_busy", busy, 1'b0);
    tick();

    // SLOT_CYCLES=1 instance.
    x       = 1'b1;
    y       = 1'b1;
    en_fast = 1'b1;
    tick();
    en_fast = 1'b0;
    checkOutput("fast_e1_sel", sel_fast, 1'b0);
    checkOutput("fast_e1_busy", busy_fast, 1'b1);
    checkOutput("fast_e1_valid_a", valid_a_fast, 1'b0);
    tick();
    checkOutput("fast_e2_valid_a", valid_a_fast, 1'b1);
    checkOutput("fast_e2_ch_a", ch_a_fast[0], 1'b1);
    checkOutput("fast_e2_sel", sel_fast, 1'b1);
    tick();
    checkOutput("fast_e3_valid_b", valid_b_fast, 1'b1);
    checkOutput("fast_e3_frame_done", frame_done_fast, 1'b1);
    checkOutput("fast_e3_ch_b", ch_b_fast[0], 1'b1);
    checkOutput("fast_e3_sel", sel_fast, 1'b0);
    checkOutput("fast_e3_busy", busy_fast, 1'b0);
    tick();

    // en drops during SLOT_A: frame completes, then a fresh frame from IDLE.
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("drop_valid_a", valid_a, 1'b1);
    checkOutput("drop_ch_a", ch_a[0], 1'b1);
    tick();
    tick();
    checkOutput("drop_valid_b", valid_b, 1'b1);
    checkOutput("drop_ch_b", ch_b[0], 1'b0);
    checkOutput("drop_busy", busy, 1'b0);
    tick();
    checkOutput("drop_idle_busy", busy, 1'b0);
    checkOutput("drop_idle_valid_a", valid_a, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("refire_busy", busy, 1'b1);
    checkOutput("refire_sel", sel, 1'b0);
    tick();
    tick();
    checkOutput("refire_valid_a", valid_a, 1'b1);
    checkOutput("refire_ch_a", ch_a[0], 1'b0);
    tick();
    tick();
    checkOutput("refire_frame_done", frame_done, 1'b1);
    checkOutput("refire_ch_b", ch_b[0], 1'b1);
    checkOutput("refire_busy_end", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
